fetch_redirect: RTL



---
 rtl/fetch_redirect.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/fetch_redirect.sv
// fetch_redirect: fetch-stage PC generator with execute-stage redirect.
//   Holds the fetch PC and advances it by 4, or to a predicted target when the
//   optional BTB predicts taken. A jump, or a branch whose outcome disagrees
//   with its prediction, redirects fetch to the correct path, flushes the
//   younger F/D instructions and bumps a wrapping redirect counter.
//   Optional feature macro: FETCH_BTB_EN (BTB with 2-bit counters).
//   Without it, prediction is static not-taken.
// Ports:
//   clock, reset            clock and synchronous active-high reset
//   stall                   hold the fetch PC
//   e_is_branch, e_is_jump  execute-stage instruction class
//   e_br_taken              resolved branch outcome
//   e_pred_taken            prediction made when the instruction was fetched
//   e_pc, e_target          execute-stage PC and computed target
//   f_pc                    current fetch address (registered)
//   f_pred_taken            prediction for f_pc (combinational)
//   flush                   kill F/D this cycle (combinational)
//   redirect_count          redirects since reset (registered, wraps)
module fetch_redirect #(
  parameter logic [31:0] RESET_PC    = 32'h01000000,
  parameter int unsigned BTB_ENTRIES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        e_is_branch,
  input  logic        e_is_jump,
  input  logic        e_br_taken,
  input  logic        e_pred_taken,
  input  logic [31:0] e_pc,
  input  logic [31:0] e_target,
  output logic [31:0] f_pc,
  output logic        f_pred_taken,
  output logic        flush,
  output logic [15:0] redirect_count
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 16;

  logic [XLEN-1:0]  f_pc_q, f_pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             redirect_c;
  logic [XLEN-1:0]  redirect_pc_c;
  logic             pred_c;
  logic [XLEN-1:0]  pred_target_c;

  // Resolution: jumps always redirect, branches only when mispredicted.
  always_comb begin
    redirect_c    = e_is_jump | (e_is_branch & (e_br_taken != e_pred_taken));
    redirect_pc_c = (e_is_jump | e_br_taken) ? e_target : e_pc + XLEN'(4);
  end

`ifdef FETCH_BTB_EN
  localparam int unsigned IDX   = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX - 2;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    logic [1:0]       ctr;
  } btb_entry_t;

  btb_entry_t     btb_q [BTB_ENTRIES];
  logic [IDX-1:0] rd_idx_c, wr_idx_c;
  btb_entry_t     rd_entry_c, upd_old_c, wr_entry_c;
  logic           upd_hit_c, wr_en_c;

  // Lookup on the fetch PC; reads the registered array so a same-cycle
  // update to the same entry is only seen next cycle.
  always_comb begin
    rd_idx_c      = f_pc_q[IDX+1:2];
    rd_entry_c    = btb_q[rd_idx_c];
    pred_c        = rd_entry_c.valid & (rd_entry_c.tag == f_pc_q[XLEN-1:IDX+2])
                    & rd_entry_c.ctr[1];
    pred_target_c = rd_entry_c.target;
  end

  // Training from resolved conditional branches only.
  always_comb begin
    wr_idx_c   = e_pc[IDX+1:2];
    upd_old_c  = btb_q[wr_idx_c];
    upd_hit_c  = upd_old_c.valid & (upd_old_c.tag == e_pc[XLEN-1:IDX+2]);
    wr_en_c    = 1'b0;
    wr_entry_c = upd_old_c;
    if (e_is_branch) begin
      if (upd_hit_c) begin
        wr_en_c = 1'b1;
        if (e_br_taken) begin
          if (upd_old_c.ctr != 2'b11) wr_entry_c.ctr = upd_old_c.ctr + 2'd1;
          wr_entry_c.target = e_target;
        end else if (upd_old_c.ctr != 2'b00) begin
          wr_entry_c.ctr = upd_old_c.ctr - 2'd1;
        end
      end else if (e_br_taken) begin
        wr_en_c           = 1'b1;
        wr_entry_c.valid  = 1'b1;
        wr_entry_c.tag    = e_pc[XLEN-1:IDX+2];
        wr_entry_c.target = e_target;
        wr_entry_c.ctr    = 2'b10;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(BTB_ENTRIES); i++) btb_q[i] <= '0;
    end else if (wr_en_c) begin
      btb_q[wr_idx_c] <= wr_entry_c;
    end
  end
`else
  // Static not-taken: no storage, BTB_ENTRIES has no effect.
  logic unused_cfg;
  assign unused_cfg = ^BTB_ENTRIES;

  always_comb begin
    pred_c        = 1'b0;
    pred_target_c = '0;
  end
`endif

  // Next fetch PC: redirect beats stall, stall beats prediction.
  always_comb begin
    f_pc_d = f_pc_q + XLEN'(4);
    cnt_d  = cnt_q;
    if (redirect_c) begin
      f_pc_d = redirect_pc_c;
      cnt_d  = cnt_q + CNT_W'(1);
    end else if (stall) begin
      f_pc_d = f_pc_q;
    end else if (pred_c) begin
      f_pc_d = pred_target_c;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      f_pc_q <= RESET_PC;
      cnt_q  <= '0;
    end else begin
      f_pc_q <= f_pc_d;
      cnt_q  <= cnt_d;
    end
  end

  assign f_pc           = f_pc_q;
  assign f_pred_taken   = pred_c;
  assign flush          = redirect_c;
  assign redirect_count = cnt_q;

endmodule
